// File: rtl/race_progress_pkg.sv
// race_pkg: shared types for the race_progress lap/checkpoint tracker.
// Holds the FSM state encoding, the region rectangle record and the
// disabled-region constant used at reset.
package race_pkg;

  // Widest coordinate the region table can hold. The top zero-extends its
  // COORD_W inputs into this width, so COORD_W may be anything up to 16.
  localparam int COORD_MAX_W = 16;

  typedef logic [COORD_MAX_W-1:0] coord_t;

  // Encoding is visible on the debug/HUD state port, so values are fixed.
  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    RACING    = 2'd1,
    IN_FINISH = 2'd2,
    DONE      = 2'd3
  } race_state_e;

  // Inclusive rectangle in screen pixels.
  typedef struct packed {
    coord_t x_min;
    coord_t x_max;
    coord_t y_min;
    coord_t y_max;
  } region_t;

  // min > max on both axes, so a reset entry can never report a hit.
  localparam region_t REGION_DISABLED = '{
    x_min: '1,
    x_max: '0,
    y_min: '1,
    y_max: '0
  };

  // A region with an inverted axis is treated as switched off, whatever
  // the car box looks like.
  function automatic logic region_enabled(input region_t r);
    return (r.x_min <= r.x_max) && (r.y_min <= r.y_max);
  endfunction

endpackage

// File: rtl/race_progress_region_hit.sv
// region_hit: purely combinational test of whether the car bounding box lies
// completely inside one region rectangle (all bounds inclusive, unsigned).
module region_hit
  import race_pkg::*;
(
  input  region_t i_region,
  input  coord_t  i_x_start,
  input  coord_t  i_x_end,
  input  coord_t  i_y_start,
  input  coord_t  i_y_end,
  output logic    o_hit
);

  logic w_inside;

  assign w_inside = (i_x_start >= i_region.x_min) &&
                    (i_x_end   <= i_region.x_max) &&
                    (i_y_start >= i_region.y_min) &&
                    (i_y_end   <= i_region.y_max);

  // The explicit enable term matters: an inverted car box could otherwise
  // satisfy the four compares against an inverted (disabled) region.
  assign o_hit = w_inside && region_enabled(i_region);

endmodule

// File: rtl/race_progress.sv
// race_progress: lap and checkpoint tracker for one car.
// A runtime-written table holds NUM_CP checkpoint rectangles plus one finish
// rectangle. On each sample strobe the car box is tested against every entry;
// the FSM tracks which checkpoints were passed in the current lap and counts
// completed laps up to TOTAL_LAPS.
// Optional build macro: RACE_PROGRESS_LAP_TIMER_EN adds per-lap timing
// outputs (last_lap_time, best_lap_time), measured in samples.
module race_progress
  import race_pkg::*;
#(
  parameter int NUM_CP     = 6,
  parameter int COORD_W    = 11,
  parameter int LAP_W      = 4,
  parameter int TOTAL_LAPS = 3,
  parameter int ORDERED    = 0,
  parameter int TIMER_W    = 16
) (
  input  logic                         pclk,
  input  logic                         rst,
  input  logic                         start,
  input  logic                         sample,
  input  logic [COORD_W-1:0]           car_x_start,
  input  logic [COORD_W-1:0]           car_x_end,
  input  logic [COORD_W-1:0]           car_y_start,
  input  logic [COORD_W-1:0]           car_y_end,
  input  logic                         cfg_we,
  input  logic [$clog2(NUM_CP+1)-1:0]  cfg_idx,
  input  logic [COORD_W-1:0]           cfg_x_min,
  input  logic [COORD_W-1:0]           cfg_x_max,
  input  logic [COORD_W-1:0]           cfg_y_min,
  input  logic [COORD_W-1:0]           cfg_y_max,
  output logic [NUM_CP-1:0]            cp_mask,
  output logic                         checkpoints_passed,
  output logic                         lap_finished,
  output logic [LAP_W-1:0]             lap_count,
  output logic                         wrong_order,
  output logic                         race_done,
  output logic [1:0]                   state
`ifdef RACE_PROGRESS_LAP_TIMER_EN
  ,
  output logic [TIMER_W-1:0]           last_lap_time,
  output logic [TIMER_W-1:0]           best_lap_time
`endif
);

  localparam int NUM_REGIONS = NUM_CP + 1;
  localparam int FINISH_IDX  = NUM_CP;

  // ---------------------------------------------------------------------------
  // Region table
  // ---------------------------------------------------------------------------
  region_t r_table [NUM_REGIONS];

  // Write one table entry; indices past the finish entry are dropped.
  // NOTE: the table is reset on purpose -- "disabled" is a functional state
  // the tracker relies on, not just a power-up nicety.
  always_ff @(posedge pclk) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGIONS; i++) begin
        r_table[i] <= REGION_DISABLED;
      end
    end else if (cfg_we && (int'(cfg_idx) <= FINISH_IDX)) begin
      r_table[cfg_idx] <= '{
        x_min: coord_t'(cfg_x_min),
        x_max: coord_t'(cfg_x_max),
        y_min: coord_t'(cfg_y_min),
        y_max: coord_t'(cfg_y_max)
      };
    end
  end

  // ---------------------------------------------------------------------------
  // Hit detection against every entry
  // ---------------------------------------------------------------------------
  logic [NUM_REGIONS-1:0] w_hit;
  logic [NUM_CP-1:0]      w_cp_hit;
  logic                   w_fin_hit;

  for (genvar g = 0; g < NUM_REGIONS; g++) begin : g_region
    region_hit u_region_hit (
      .i_region  (r_table[g]),
      .i_x_start (coord_t'(car_x_start)),
      .i_x_end   (coord_t'(car_x_end)),
      .i_y_start (coord_t'(car_y_start)),
      .i_y_end   (coord_t'(car_y_end)),
      .o_hit     (w_hit[g])
    );
  end

  assign w_cp_hit  = w_hit[NUM_CP-1:0];
  assign w_fin_hit = w_hit[FINISH_IDX];

  // ---------------------------------------------------------------------------
  // Checkpoint acceptance (ordering rule)
  // ---------------------------------------------------------------------------
  race_state_e       r_state;
  logic [NUM_CP-1:0] r_cp_mask;
  logic [LAP_W-1:0]  r_lap_count;
  logic              r_lap_finished;
  logic              r_wrong_order;
  logic              r_race_done;

  logic [NUM_CP-1:0] w_in_order;
  logic [NUM_CP-1:0] w_cp_set;
  logic [NUM_CP-1:0] w_cp_bad;

  // Bit i may be taken only once every lower checkpoint is already in the mask.
  // NOTE: every always_comb output gets a default before any conditional
  // logic, so no path can leave it unassigned and infer a latch.
  always_comb begin
    w_in_order    = '0;
    w_in_order[0] = 1'b1;
    for (int i = 1; i < NUM_CP; i++) begin
      w_in_order[i] = w_in_order[i-1] & r_cp_mask[i-1];
    end
  end

  if (ORDERED != 0) begin : g_ordered
    assign w_cp_set = w_cp_hit & w_in_order;
    // A re-hit of a checkpoint already in the mask is not an ordering error.
    assign w_cp_bad = w_cp_hit & ~w_in_order & ~r_cp_mask;
  end else begin : g_any_order
    assign w_cp_set = w_cp_hit;
    assign w_cp_bad = '0;
  end

  // start takes priority: a sample arriving together with start is dropped.
  logic w_eval;
  logic w_lap_event;

  assign w_eval      = sample && !start;
  assign w_lap_event = w_eval && (r_state == RACING) && w_fin_hit && (&r_cp_mask);

  // ---------------------------------------------------------------------------
  // Race FSM with registered outputs
  // ---------------------------------------------------------------------------
  // Advance the race state, checkpoint mask and lap counter.
  // NOTE: sequential state is updated with non-blocking assignments only, so
  // every register sees the pre-edge value of every other register.
  always_ff @(posedge pclk) begin
    if (rst) begin
      r_state        <= IDLE;
      r_cp_mask      <= '0;
      r_lap_count    <= '0;
      r_lap_finished <= 1'b0;
      r_wrong_order  <= 1'b0;
      r_race_done    <= 1'b0;
    end else begin
      r_lap_finished <= 1'b0;
      r_wrong_order  <= 1'b0;
      if (start) begin
        r_state     <= RACING;
        r_cp_mask   <= '0;
        r_lap_count <= '0;
        r_race_done <= 1'b0;
      end else if (sample) begin
        case (r_state)
          RACING: begin
            if (w_lap_event) begin
              // Checkpoints hit on the same sample belong to no lap; drop them.
              r_lap_finished <= 1'b1;
              r_cp_mask      <= '0;
              r_lap_count    <= r_lap_count + 1'b1;
              if (r_lap_count == LAP_W'(TOTAL_LAPS - 1)) begin
                r_state     <= DONE;
                r_race_done <= 1'b1;
              end else begin
                r_state <= IN_FINISH;
              end
            end else begin
              r_cp_mask     <= r_cp_mask | w_cp_set;
              r_wrong_order <= |w_cp_bad;
              if (w_fin_hit) begin
                r_state <= IN_FINISH;
              end
            end
          end
          IN_FINISH: begin
            // Leaving the finish area re-arms lap counting; checkpoints are
            // not scored while the car is considered inside the finish.
            if (!w_fin_hit) begin
              r_state <= RACING;
            end
          end
          default: ;  // IDLE and DONE wait for start
        endcase
      end
    end
  end

  assign cp_mask            = r_cp_mask;
  assign checkpoints_passed = &r_cp_mask;
  assign lap_finished       = r_lap_finished;
  assign lap_count          = r_lap_count;
  assign wrong_order        = r_wrong_order;
  assign race_done          = r_race_done;
  assign state              = r_state;

`ifdef RACE_PROGRESS_LAP_TIMER_EN
  // ---------------------------------------------------------------------------
  // Lap timer (in samples)
  // ---------------------------------------------------------------------------
  logic [TIMER_W-1:0] r_timer;
  logic [TIMER_W-1:0] r_last_lap;
  logic [TIMER_W-1:0] r_best_lap;
  logic [TIMER_W-1:0] w_timer_next;
  logic               w_timing;

  assign w_timing     = w_eval && ((r_state == RACING) || (r_state == IN_FINISH));
  assign w_timer_next = (&r_timer) ? r_timer : r_timer + 1'b1;

  // Count samples in the current lap and latch last/best on lap completion.
  // The best time survives start and is cleared only by rst.
  always_ff @(posedge pclk) begin
    if (rst) begin
      r_timer    <= '0;
      r_last_lap <= '0;
      r_best_lap <= '0;
    end else if (start) begin
      r_timer    <= '0;
      r_last_lap <= '0;
    end else if (w_timing) begin
      if (w_lap_event) begin
        r_timer    <= '0;
        r_last_lap <= w_timer_next;
        if ((r_best_lap == '0) || (w_timer_next < r_best_lap)) begin
          r_best_lap <= w_timer_next;
        end
      end else begin
        r_timer <= w_timer_next;
      end
    end
  end

  assign last_lap_time = r_last_lap;
  assign best_lap_time = r_best_lap;
`endif

endmodule

// File: tb/tb_race_progress.sv
// Scoreboard bench for race_progress. Directed stimulus pushes a hand-computed
// expected output record after every clock edge; an independent monitor pops
// and compares on the following falling edge. dut0 is the default
// (any-order) build, dut1 the ORDERED=1 build sharing the same table writes.
module tb_race_progress;

  localparam int NUM_CP  = 6;
  localparam int COORD_W = 11;
  localparam int LAP_W   = 4;
  localparam int TIMER_W = 16;

  logic               pclk = 1'b0;
  logic               rst = 1'b1;
  logic               start = 1'b0;
  logic               start1 = 1'b0;
  logic               sample = 1'b0;
  logic [COORD_W-1:0] car_x_start = '0;
  logic [COORD_W-1:0] car_x_end = '0;
  logic [COORD_W-1:0] car_y_start = '0;
  logic [COORD_W-1:0] car_y_end = '0;
  logic               cfg_we = 1'b0;
  logic [2:0]         cfg_idx = '0;
  logic [COORD_W-1:0] cfg_x_min = '0;
  logic [COORD_W-1:0] cfg_x_max = '0;
  logic [COORD_W-1:0] cfg_y_min = '0;
  logic [COORD_W-1:0] cfg_y_max = '0;

  logic [NUM_CP-1:0] cp_mask0, cp_mask1;
  logic              cpp0, cpp1, lf0, lf1, wo0, wo1, done0, done1;
  logic [LAP_W-1:0]  lc0, lc1;
  logic [1:0]        st0, st1;
`ifdef RACE_PROGRESS_LAP_TIMER_EN
  logic [TIMER_W-1:0] last0, best0, last1, best1;
`endif

  always #5 pclk = ~pclk;

  race_progress #(.ORDERED(0)) dut0 (
    .pclk(pclk), .rst(rst), .start(start), .sample(sample),
    .car_x_start(car_x_start), .car_x_end(car_x_end),
    .car_y_start(car_y_start), .car_y_end(car_y_end),
    .cfg_we(cfg_we), .cfg_idx(cfg_idx),
    .cfg_x_min(cfg_x_min), .cfg_x_max(cfg_x_max),
    .cfg_y_min(cfg_y_min), .cfg_y_max(cfg_y_max),
    .cp_mask(cp_mask0), .checkpoints_passed(cpp0), .lap_finished(lf0),
    .lap_count(lc0), .wrong_order(wo0), .race_done(done0), .state(st0)
`ifdef RACE_PROGRESS_LAP_TIMER_EN
    , .last_lap_time(last0), .best_lap_time(best0)
`endif
  );

  race_progress #(.ORDERED(1)) dut1 (
    .pclk(pclk), .rst(rst), .start(start1), .sample(sample),
    .car_x_start(car_x_start), .car_x_end(car_x_end),
    .car_y_start(car_y_start), .car_y_end(car_y_end),
    .cfg_we(cfg_we), .cfg_idx(cfg_idx),
    .cfg_x_min(cfg_x_min), .cfg_x_max(cfg_x_max),
    .cfg_y_min(cfg_y_min), .cfg_y_max(cfg_y_max),
    .cp_mask(cp_mask1), .checkpoints_passed(cpp1), .lap_finished(lf1),
    .lap_count(lc1), .wrong_order(wo1), .race_done(done1), .state(st1)
`ifdef RACE_PROGRESS_LAP_TIMER_EN
    , .last_lap_time(last1), .best_lap_time(best1)
`endif
  );

  // d: 0 = check dut0, 1 = check dut1, 2 = no check for this cycle
  typedef struct {
    int               d;
    logic [NUM_CP-1:0] m;
    logic [LAP_W-1:0] lc;
    logic [1:0]       st;
    logic             lf;
    logic             wo;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: one expected record per clock edge, compared on the falling edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge pclk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        if (e.d == 0) begin
          check("d0 cp_mask", 32'(cp_mask0), 32'(e.m));
          check("d0 lap_count", 32'(lc0), 32'(e.lc));
          check("d0 state", 32'(st0), 32'(e.st));
          check("d0 lap_finished", 32'(lf0), 32'(e.lf));
          check("d0 wrong_order", 32'(wo0), 32'(e.wo));
          check("d0 race_done", 32'(done0), 32'(e.st == 2'd3));
          check("d0 checkpoints_passed", 32'(cpp0), 32'(&e.m));
        end else if (e.d == 1) begin
          check("d1 cp_mask", 32'(cp_mask1), 32'(e.m));
          check("d1 lap_count", 32'(lc1), 32'(e.lc));
          check("d1 state", 32'(st1), 32'(e.st));
          check("d1 lap_finished", 32'(lf1), 32'(e.lf));
          check("d1 wrong_order", 32'(wo1), 32'(e.wo));
          check("d1 race_done", 32'(done1), 32'(e.st == 2'd3));
          check("d1 checkpoints_passed", 32'(cpp1), 32'(&e.m));
        end
      end
    end
  end

  // One clock: the stimulus currently driven is applied at the edge, the
  // expected post-edge outputs are queued, then all strobes drop.
  task automatic tick(input int d, input logic [NUM_CP-1:0] m, input logic [LAP_W-1:0] lc,
                      input logic [1:0] st, input logic lf, input logic wo);
    exp_t e;
    e.d = d; e.m = m; e.lc = lc; e.st = st; e.lf = lf; e.wo = wo;
    @(posedge pclk);
    exp_q.push_back(e);
    #1;
    rst = 1'b0; start = 1'b0; start1 = 1'b0; sample = 1'b0; cfg_we = 1'b0;
  endtask

  task automatic set_car(input int xs, input int xe, input int ys, input int ye);
    car_x_start = COORD_W'(xs); car_x_end = COORD_W'(xe);
    car_y_start = COORD_W'(ys); car_y_end = COORD_W'(ye);
  endtask

  // Checkpoint i occupies x 80i..80i+60, y 300..400; finish x 506..529, y 0..160.
  task automatic s_cp(input int i);
    sample = 1'b1; set_car(80*i + 10, 80*i + 30, 320, 340);
  endtask
  task automatic s_fin();
    sample = 1'b1; set_car(510, 520, 10, 30);
  endtask
  task automatic s_off();
    sample = 1'b1; set_car(700, 720, 700, 720);
  endtask

  task automatic cfg(input int idx, input int xmin, input int xmax, input int ymin, input int ymax);
    cfg_we = 1'b1; cfg_idx = 3'(idx);
    cfg_x_min = COORD_W'(xmin); cfg_x_max = COORD_W'(xmax);
    cfg_y_min = COORD_W'(ymin); cfg_y_max = COORD_W'(ymax);
  endtask

  // Program the whole table while in IDLE.
  task automatic prog(input int d);
    for (int i = 0; i < NUM_CP; i++) begin
      cfg(i, 80*i, 80*i + 60, 300, 400); tick(d, 6'h00, 4'd0, 2'd0, 1'b0, 1'b0);
    end
    cfg(6, 506, 529, 0, 160); tick(d, 6'h00, 4'd0, 2'd0, 1'b0, 1'b0);
  endtask

  // Full lap from RACING with an empty mask: checkpoints 0..5 then finish.
  task automatic run_lap(input int d, input logic [LAP_W-1:0] lc_old, input logic [1:0] st_end);
    for (int i = 0; i < NUM_CP; i++) begin
      s_cp(i); tick(d, NUM_CP'((1 << (i + 1)) - 1), lc_old, 2'd1, 1'b0, 1'b0);
    end
    s_fin(); tick(d, 6'h00, lc_old + 4'd1, st_end, 1'b1, 1'b0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // ---------------- reset and table programming (dut0) ----------------
    rst = 1'b1; tick(0, 6'h00, 4'd0, 2'd0, 1'b0, 1'b0);
    rst = 1'b1; tick(0, 6'h00, 4'd0, 2'd0, 1'b0, 1'b0);
    prog(0);
    s_cp(0); tick(0, 6'h00, 4'd0, 2'd0, 1'b0, 1'b0);       // IDLE ignores samples
    start = 1'b1; tick(0, 6'h00, 4'd0, 2'd1, 1'b0, 1'b0);

    // ---------------- any-order checkpoints, incomplete finish ----------
    s_off();  tick(0, 6'h00, 4'd0, 2'd1, 1'b0, 1'b0);
    s_cp(2);  tick(0, 6'h04, 4'd0, 2'd1, 1'b0, 1'b0);
    s_cp(0);  tick(0, 6'h05, 4'd0, 2'd1, 1'b0, 1'b0);
    s_cp(1);  tick(0, 6'h07, 4'd0, 2'd1, 1'b0, 1'b0);
    s_fin();  tick(0, 6'h07, 4'd0, 2'd2, 1'b0, 1'b0);      // no lap counted
    s_off();  tick(0, 6'h07, 4'd0, 2'd1, 1'b0, 1'b0);
    s_cp(3);  tick(0, 6'h0F, 4'd0, 2'd1, 1'b0, 1'b0);
    s_cp(4);  tick(0, 6'h1F, 4'd0, 2'd1, 1'b0, 1'b0);
    s_cp(5);  tick(0, 6'h3F, 4'd0, 2'd1, 1'b0, 1'b0);
    tick(0, 6'h3F, 4'd0, 2'd1, 1'b0, 1'b0);                // no sample: hold
    s_fin();  tick(0, 6'h00, 4'd1, 2'd2, 1'b1, 1'b0);      // lap 1
    tick(0, 6'h00, 4'd1, 2'd2, 1'b0, 1'b0);                // pulse is one cycle

    // ---------------- parking in the finish region ---------------------
    for (int k = 0; k < 5; k++) begin
      s_fin(); tick(0, 6'h00, 4'd1, 2'd2, 1'b0, 1'b0);
    end
    s_cp(0);  tick(0, 6'h00, 4'd1, 2'd1, 1'b0, 1'b0);      // leaves; cp ignored
    s_fin();  tick(0, 6'h00, 4'd1, 2'd2, 1'b0, 1'b0);      // re-entry, no lap
    s_off();  tick(0, 6'h00, 4'd1, 2'd1, 1'b0, 1'b0);

    // ---------------- laps 2 and 3, DONE ------------------------------
    run_lap(0, 4'd1, 2'd2);
    s_off();  tick(0, 6'h00, 4'd2, 2'd1, 1'b0, 1'b0);
    run_lap(0, 4'd2, 2'd3);
    s_cp(0);  tick(0, 6'h00, 4'd3, 2'd3, 1'b0, 1'b0);
    s_fin();  tick(0, 6'h00, 4'd3, 2'd3, 1'b0, 1'b0);
    start = 1'b1; s_fin(); tick(0, 6'h00, 4'd0, 2'd1, 1'b0, 1'b0);  // start wins
    s_cp(0);  tick(0, 6'h01, 4'd0, 2'd1, 1'b0, 1'b0);
    start = 1'b1; tick(0, 6'h00, 4'd0, 2'd1, 1'b0, 1'b0);           // restart from RACING

    // ---------------- hit-rule boundaries --------------------------------
    sample = 1'b1; set_car(80, 141, 300, 400); tick(0, 6'h00, 4'd0, 2'd1, 1'b0, 1'b0);
    sample = 1'b1; set_car(80, 140, 300, 400); tick(0, 6'h02, 4'd0, 2'd1, 1'b0, 1'b0);
    cfg(0, 600, 500, 300, 400); tick(0, 6'h02, 4'd0, 2'd1, 1'b0, 1'b0);
    sample = 1'b1; set_car(600, 500, 320, 340); tick(0, 6'h02, 4'd0, 2'd1, 1'b0, 1'b0);
    s_cp(0);  tick(0, 6'h02, 4'd0, 2'd1, 1'b0, 1'b0);
    cfg(0, 0, 60, 300, 400); tick(0, 6'h02, 4'd0, 2'd1, 1'b0, 1'b0);
    s_cp(0);  tick(0, 6'h03, 4'd0, 2'd1, 1'b0, 1'b0);      // mid-race write effective

    // ---------------- reset mid-race clears table --------------------
    rst = 1'b1; tick(0, 6'h00, 4'd0, 2'd0, 1'b0, 1'b0);
    start = 1'b1; tick(0, 6'h00, 4'd0, 2'd1, 1'b0, 1'b0);
    s_cp(2);  tick(0, 6'h00, 4'd0, 2'd1, 1'b0, 1'b0);
    s_fin();  tick(0, 6'h00, 4'd0, 2'd1, 1'b0, 1'b0);

    // ---------------- ordered mode (dut1) ------------------------------
    rst = 1'b1; tick(1, 6'h00, 4'd0, 2'd0, 1'b0, 1'b0);
    prog(1);
    start1 = 1'b1; tick(1, 6'h00, 4'd0, 2'd1, 1'b0, 1'b0);
    s_cp(2);  tick(1, 6'h00, 4'd0, 2'd1, 1'b0, 1'b1);
    tick(1, 6'h00, 4'd0, 2'd1, 1'b0, 1'b0);
    s_cp(0);  tick(1, 6'h01, 4'd0, 2'd1, 1'b0, 1'b0);
    s_cp(1);  tick(1, 6'h03, 4'd0, 2'd1, 1'b0, 1'b0);
    s_cp(2);  tick(1, 6'h07, 4'd0, 2'd1, 1'b0, 1'b0);
    s_cp(2);  tick(1, 6'h07, 4'd0, 2'd1, 1'b0, 1'b0);      // re-hit is fine
    s_cp(5);  tick(1, 6'h07, 4'd0, 2'd1, 1'b0, 1'b1);
    s_cp(3);  tick(1, 6'h0F, 4'd0, 2'd1, 1'b0, 1'b0);

`ifdef RACE_PROGRESS_LAP_TIMER_EN
    // ---------------- lap timer: 40-sample lap then 30-sample lap ------
    rst = 1'b1; tick(2, 6'h00, 4'd0, 2'd0, 1'b0, 1'b0);
    prog(2);
    start = 1'b1; tick(2, 6'h00, 4'd0, 2'd1, 1'b0, 1'b0);
    for (int i = 0; i < NUM_CP; i++) begin s_cp(i); tick(2, 6'h00, 4'd0, 2'd0, 1'b0, 1'b0); end
    for (int k = 0; k < 33; k++) begin s_off(); tick(2, 6'h00, 4'd0, 2'd0, 1'b0, 1'b0); end
    s_fin(); tick(2, 6'h00, 4'd0, 2'd0, 1'b0, 1'b0);
    check("last_lap_time lap1", 32'(last0), 32'd40);
    check("best_lap_time lap1", 32'(best0), 32'd40);
    s_off(); tick(2, 6'h00, 4'd0, 2'd0, 1'b0, 1'b0);
    for (int i = 0; i < NUM_CP; i++) begin s_cp(i); tick(2, 6'h00, 4'd0, 2'd0, 1'b0, 1'b0); end
    for (int k = 0; k < 22; k++) begin s_off(); tick(2, 6'h00, 4'd0, 2'd0, 1'b0, 1'b0); end
    s_fin(); tick(2, 6'h00, 4'd0, 2'd0, 1'b0, 1'b0);
    check("last_lap_time lap2", 32'(last0), 32'd30);
    check("best_lap_time lap2", 32'(best0), 32'd30);
    check("lap_count after timed laps", 32'(lc0), 32'd2);
`endif

    repeat (3) @(negedge pclk);
    check("scoreboard drained", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/race_progress.md
Name: race_progress

Overview:
- Parametrised lap and checkpoint tracker for one car.
- Holds a runtime-programmable table of NUM_CP checkpoint rectangles plus one finish rectangle.
- Tests the car bounding box against the table on each sample strobe; tracks which checkpoints were passed (any order or strict order) and counts completed laps up to TOTAL_LAPS.
- Sits between the car position logic and the game-state / HUD logic.

Parameters:
- NUM_CP, 6, number of checkpoint regions (1..16).
- COORD_W, 11, coordinate width in pixels.
- LAP_W, 4, lap counter width.
- TOTAL_LAPS, 3, laps needed to finish the race (1..2^LAP_W-1).
- ORDERED, 0, 1 = checkpoints must be passed in index order.
- TIMER_W, 16, lap timer width in samples (used only with LAP_TIMER_EN).

Ports:
- pclk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- start  in  1  pulse; begins a race from IDLE or DONE.
- sample  in  1  strobe; evaluate the car position on this cycle (typically once per frame).
- car_x_start, car_x_end, car_y_start, car_y_end  in  COORD_W each  car bounding box, inclusive.
- cfg_we  in  1  region table write enable.
- cfg_idx  in  $clog2(NUM_CP+1)  region index; 0..NUM_CP-1 are checkpoints, NUM_CP is the finish region.
- cfg_x_min, cfg_x_max, cfg_y_min, cfg_y_max  in  COORD_W each  region bounds, inclusive.
- cp_mask  out  NUM_CP  checkpoints passed in the current lap.
- checkpoints_passed  out  1  cp_mask is all ones.
- lap_finished  out  1  one-cycle pulse when a lap completes.
- lap_count  out  LAP_W  completed laps.
- wrong_order  out  1  one-cycle pulse; ORDERED=1 only, tied 0 otherwise.
- race_done  out  1  high in DONE.
- state  out  2  current FSM state (for debug / HUD).

Behaviour:
- Reset values: all outputs 0; state IDLE.
- Every table entry resets to disabled: x_min = all ones, x_max = 0.
- Table write: on cfg_we, entry cfg_idx is updated at the clock edge. A cfg_idx above NUM_CP is ignored. A write has effect from the next sample onward, including mid-race.
- Hit rule: hit when car_x_start>=x_min, car_x_end<=x_max, car_y_start>=y_min and car_y_end<=y_max (unsigned). Entries with min>max never hit.
- Inputs are evaluated only on cycles with sample=1. All resulting outputs are registered and change one cycle after the sample cycle.
- FSM states: IDLE=0, RACING=1, IN_FINISH=2, DONE=3.
- IDLE, on start: go to RACING; clear cp_mask and lap_count.
- RACING, on sample:
  - Each hit checkpoint i sets bit i of cp_mask.
  - If ORDERED=1, bit i is set only if bits 0..i-1 are already set. Otherwise pulse wrong_order and leave the mask unchanged. Re-hitting an already-set checkpoint is not an error.
  - If the finish region is hit:
    - If cp_mask (the value before this sample) is all ones: pulse lap_finished, increment lap_count, clear cp_mask, go to IN_FINISH.
    - Otherwise, go to IN_FINISH with no lap counted.
  - Checkpoint hits in the same sample as a counting finish hit are discarded.
- IN_FINISH: checkpoint hits are ignored. On a sample with no finish hit, return to RACING. A lap therefore counts once per entry into the finish region.
- When the increment makes lap_count equal TOTAL_LAPS, go to DONE instead of IN_FINISH. lap_count saturates and race_done=1.
- DONE: hold all outputs. start restarts the race as from IDLE.
- start in RACING or IN_FINISH also restarts (clears counts, goes to RACING).
- start on a sample cycle: start wins and the sample is dropped.
- rst mid-race: returns everything, including the table, to reset values.
- checkpoints_passed is derived from the registered cp_mask, with zero added latency.

Optional Feature:
- Macro: RACE_PROGRESS_LAP_TIMER_EN.
- When defined:
  - Adds outputs last_lap_time [TIMER_W] and best_lap_time [TIMER_W].
  - A TIMER_W counter increments on each sample in RACING or IN_FINISH and saturates at all ones.
  - On lap_finished: the counter value (including the finishing sample) goes to last_lap_time; best_lap_time is updated if the new time is smaller or best is 0; the counter clears.
  - start clears the counter and last_lap_time. best_lap_time is kept until rst.
- When undefined: the ports and logic are absent.

Decomposition:
- Package race_pkg: state enum (IDLE, RACING, IN_FINISH, DONE), region struct {x_min, x_max, y_min, y_max}, and the disabled-region constant.
- One sub-module, region_hit: combinational bounding-box-in-region compare, instantiated NUM_CP+1 times.

Test Plan:
- Program checkpoints 0..5 and finish (506..529, 0..160), start, pass checkpoints 0..5, enter finish -> lap_finished pulse 1 cycle after the sample, lap_count=1, cp_mask=0.
- Park in the finish region for 5 samples after a lap -> only one lap_finished, lap_count stays 1. Leave, then re-enter without checkpoints -> no lap.
- ORDERED=1: hit checkpoint 2 before 1 -> wrong_order pulse, cp_mask unchanged. Then 0,1,2 -> cp_mask=6'b000111.
- TOTAL_LAPS=3: complete 3 laps -> race_done=1, state=DONE, further finish hits are ignored; start -> lap_count=0, state=RACING.
- Region written with x_min=600, x_max=500 -> never hits. rst mid-race -> all outputs 0 and table disabled.
- With RACE_PROGRESS_LAP_TIMER_EN: laps of 40 and 30 samples -> last_lap_time=30, best_lap_time=30.
